// File: rtl/store_write_buffer.sv
// =============================================================================
// Module : store_write_buffer
// Brief  : Store-side alignment/byte-enable generation feeding a small FIFO
//          that drains to data memory, with word-granular load-conflict flag.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module store_write_buffer #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StoreValid,
    input  logic [1:0]  StoreType,
    input  logic [31:0] StoreAddr,
    input  logic [31:0] StoreData,
    output logic        StoreReady,
    output logic        MemWriteEn,
    output logic [29:0] MemWriteAddr,
    output logic [3:0]  MemByteEn,
    output logic [31:0] MemWriteData,
    input  logic        MemWriteAck,
    input  logic [31:0] LoadCheckAddr,
    output logic        LoadConflict,
    output logic        AddrErr,
    output logic [31:0] BadVAddr,
    output logic        BufEmpty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    localparam logic [1:0] C_TYPE_BYTE = 2'b00;
    localparam logic [1:0] C_TYPE_HALF = 2'b01;
    localparam logic [1:0] C_TYPE_WORD = 2'b10;

    // ------------------------------------------------------------------
    // Request decode: alignment, byte-enable mask, lane replication
    // ------------------------------------------------------------------
    logic        w_aligned;
    logic [3:0]  w_be;
    logic [31:0] w_data;

    always_comb begin
        w_aligned = 1'b0;
        w_be      = 4'b0000;
        w_data    = StoreData;
        case (StoreType)
            C_TYPE_BYTE: begin
                w_aligned = 1'b1;
                w_be      = 4'b0001 << StoreAddr[1:0];
                w_data    = {4{StoreData[7:0]}};
            end
            C_TYPE_HALF: begin
                w_aligned = ~StoreAddr[0];
                w_be      = StoreAddr[1] ? 4'b1100 : 4'b0011;
                w_data    = {2{StoreData[15:0]}};
            end
            C_TYPE_WORD: begin
                w_aligned = (StoreAddr[1:0] == 2'b00);
                w_be      = 4'b1111;
                w_data    = StoreData;
            end
            default: begin
                w_aligned = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic             err_q, err_d;
    logic [31:0]      badvaddr_q, badvaddr_d;

    logic [29:0] addr_q [DEPTH];
    logic [3:0]  be_q   [DEPTH];
    logic [31:0] data_q [DEPTH];

    logic w_accept;
    logic w_push;
    logic w_reject;
    logic w_pop;
    logic w_nonempty;

    // Ready depends only on registered occupancy, so an ack in a full cycle
    // cannot open a same-cycle path for a new request.
    assign StoreReady = (count_q < C_DEPTH);
    assign w_nonempty = (count_q != '0);
    assign w_accept   = StoreValid & StoreReady;
    assign w_push     = w_accept & w_aligned;
    assign w_reject   = w_accept & ~w_aligned;
    assign w_pop      = MemWriteAck & w_nonempty;

    always_comb begin
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        valid_d    = valid_q;
        err_d      = w_reject;
        badvaddr_d = badvaddr_q;

        if (w_pop) begin
            head_d          = head_q + 1'b1;
            valid_d[head_q] = 1'b0;
        end
        if (w_push) begin
            tail_d          = tail_q + 1'b1;
            valid_d[tail_q] = 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (w_reject) begin
            badvaddr_d = StoreAddr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            valid_q    <= '0;
            err_q      <= 1'b0;
            badvaddr_q <= '0;
        end else begin
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    // Payload storage needs no reset: occupancy and valid bits gate every use.
    always_ff @(posedge clk) begin
        if (w_push) begin
            addr_q[tail_q] <= StoreAddr[31:2];
            be_q[tail_q]   <= w_be;
            data_q[tail_q] <= w_data;
        end
    end

    // ------------------------------------------------------------------
    // Memory-side head presentation (forced to zero while empty)
    // ------------------------------------------------------------------
    assign MemWriteEn   = w_nonempty;
    assign MemWriteAddr = w_nonempty ? addr_q[head_q] : 30'd0;
    assign MemByteEn    = w_nonempty ? be_q[head_q]   : 4'd0;
    assign MemWriteData = w_nonempty ? data_q[head_q] : 32'd0;
    assign BufEmpty     = ~w_nonempty;
    assign AddrErr      = err_q;
    assign BadVAddr     = badvaddr_q;

    // ------------------------------------------------------------------
    // Word-granular load conflict against every occupied entry
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] w_hit;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_conflict
            assign w_hit[gi] = valid_q[gi] & (addr_q[gi] == LoadCheckAddr[31:2]);
        end
    endgenerate

    assign LoadConflict = |w_hit;

endmodule

`default_nettype wire
